icache_refill_responder: RTL

- L2-side responder for I$ line-fill requests. Accepts one miss address at a time and fetches the 64-byte line from the backing memory port as BEATS sequential beats.
- Assembles the beats into a line buffer and returns the full line on the I$ refill interface (l2_ready/l2_valid/l2_addr/l2_data).
- Sits between the I$ miss path and the L2 data array / memory bus.

---
 rtl/icache_refill_responder.sv | 115 +++++++++++
 1 files changed

// File: rtl/icache_refill_responder.sv
// I$ line-fill responder: fetches one line as BEATS single-outstanding memory beats and returns it whole.
// Two cycles per beat at full memory rate; mem_req_ready_i low stalls REQ, ic_resp_ready_i low holds RESP.
module icache_refill_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 64,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    icache_flush_i,
    input  logic                    ic_miss_valid_i,
    input  logic [ADDR_WIDTH-1:0]   ic_miss_addr_i,
    input  logic                    ic_resp_ready_i,
    output logic                    l2_ready_o,
    output logic                    l2_valid_o,
    output logic [ADDR_WIDTH-1:0]   l2_addr_o,
    output logic [LINE_SIZE*8-1:0]  l2_data_o,
    output logic                    mem_req_valid_o,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr_o,
    input  logic                    mem_req_ready_i,
    input  logic                    mem_resp_valid_i,
    input  logic [BEAT_WIDTH-1:0]   mem_resp_data_i
);
    localparam int LINE_W     = LINE_SIZE * 8;
    localparam int BEATS      = LINE_W / BEAT_WIDTH;
    localparam int BEAT_BYTES = BEAT_WIDTH / 8;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(LINE_SIZE - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [CNT_W-1:0]       beat_q, beat_d;
    logic                   drop_q, drop_d;
    logic [LINE_W-1:0]      line_q, line_d;
    logic [ADDR_WIDTH-1:0]  beat_addr;

    // Wraps modulo 2^ADDR_WIDTH by construction.
    assign beat_addr = base_q + (ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BEAT_BYTES));
    assign l2_addr_o = base_q;
    assign l2_data_o = line_q;

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        beat_d          = beat_q;
        drop_d          = drop_q;
        line_d          = line_q;
        l2_ready_o      = 1'b0;
        l2_valid_o      = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        case (state_q)
            IDLE: begin
                l2_ready_o = !icache_flush_i;
                if (ic_miss_valid_i && !icache_flush_i) begin
                    base_d  = ic_miss_addr_i & ~OFF_MASK;
                    beat_d  = '0;
                    drop_d  = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = beat_addr;
                drop_d          = drop_q | icache_flush_i;
                if (mem_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A flush only marks the line dead; the memory beat sequence always completes.
                drop_d = drop_q | icache_flush_i;
                if (mem_resp_valid_i) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (beat_q == CNT_W'(k)) begin
                            line_d[k*BEAT_WIDTH +: BEAT_WIDTH] = mem_resp_data_i;
                        end
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = (drop_q || icache_flush_i) ? IDLE : RESP;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = REQ;
                    end
                end
            end
            RESP: begin
                l2_valid_o = 1'b1;
                if (icache_flush_i || ic_resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            base_q  <= '0;
            beat_q  <= '0;
            drop_q  <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            drop_q  <= drop_d;
            line_q  <= line_d;
        end
    end
endmodule
